// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one imem read per cycle under a 2-credit
// limit, buffers returned {instr, pc} pairs in a 2-entry FIFO toward decode.
module fetch_stage #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned IW    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc_cur,
    output logic             pc_write,
    output logic [WIDTH-1:0] pc_next,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_rvalid,
    input  logic [IW-1:0]    imem_rdata,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [IW-1:0]    id_instr,
    output logic [WIDTH-1:0] id_pc
);

    localparam int unsigned DEPTH   = 2;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned OCC_W   = 3;
    localparam int unsigned PC_STEP = 4;

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_BOOT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    typedef struct packed {
        logic [IW-1:0]    instr;
        logic [WIDTH-1:0] pc;
    } entry_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    entry_t           fifo_q [DEPTH];
    entry_t           fifo_d [DEPTH];
    logic             infl_valid_q, infl_valid_d;
    logic [WIDTH-1:0] infl_pc_q, infl_pc_d;
    logic             infl_epoch_q, infl_epoch_d;
    logic             epoch_q, epoch_d;

    logic             redirect_en;
    logic             pop;
    logic             push;
    logic [OCC_W-1:0] occupancy;
    logic             credit_ok;

    // Redirects are meaningless while the block is held in reset.
    assign redirect_en = redirect & ~reset;
    assign pop         = (count_q != '0) & id_ready;
    assign push        = imem_rvalid & infl_valid_q & (infl_epoch_q == epoch_q);

    // Slot freed by this cycle's pop is reusable at once, giving 1 instr/cycle.
    assign occupancy = OCC_W'(count_q) + OCC_W'(infl_valid_q) - OCC_W'(pop);
    assign credit_ok = occupancy < OCC_W'(DEPTH);

    assign imem_addr = pc_cur;
    assign pc_write  = imem_req | redirect_en;
    assign pc_next   = redirect ? redirect_pc : pc_cur + WIDTH'(PC_STEP);

    assign id_valid  = (count_q != '0);
    assign id_instr  = fifo_q[rd_ptr_q].instr;
    assign id_pc     = fifo_q[rd_ptr_q].pc;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and request generation.
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        case (state_q)
            ST_RST: begin
                state_d = ST_BOOT;
            end
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                imem_req = ~redirect & credit_ok;
            end
            default: begin
                state_d = ST_RST;
            end
        endcase
    end

    // FIFO, in-flight tracking and epoch next-state.
    always_comb begin
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        fifo_d       = fifo_q;
        epoch_d      = epoch_q;
        infl_valid_d = imem_req;
        infl_pc_d    = infl_pc_q;
        infl_epoch_d = infl_epoch_q;

        if (imem_req) begin
            infl_pc_d    = pc_cur;
            infl_epoch_d = epoch_q;
        end

        if (redirect_en) begin
            // Flush wins over any same-cycle push or pop.
            count_d  = '0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            epoch_d  = ~epoch_q;
        end else begin
            if (push) begin
                fifo_d[wr_ptr_q].instr = imem_rdata;
                fifo_d[wr_ptr_q].pc    = infl_pc_q;
                wr_ptr_d               = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q      <= '0;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            epoch_q      <= 1'b0;
            infl_valid_q <= 1'b0;
            infl_pc_q    <= '0;
            infl_epoch_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            epoch_q      <= epoch_d;
            infl_valid_q <= infl_valid_d;
            infl_pc_q    <= infl_pc_d;
            infl_epoch_q <= infl_epoch_d;
            fifo_q       <= fifo_d;
        end
    end

endmodule
